// File: rtl/imem_fetch_resp.sv
// -----------------------------------------------------------------------------
// imem_fetch_resp
//
// Instruction-memory responder that sits behind the program counter. A fetch
// request is accepted with a byte address. The word is read from an inferred
// block RAM at the accept edge and carried through a fixed-length, never
// stalling latency pipeline. It then lands in a small response FIFO that
// drives a valid/ready response channel. Responses always come back in
// request order. Misaligned or out-of-range addresses return a NOP with the
// error flag set. A side load port writes program words into the memory.
//
// Parameters:
//   AW       word-address width (memory holds 2**AW 32-bit words)
//   LATENCY  accept edge to earliest resp_valid, in cycles (1..4)
//   OSTD     maximum outstanding requests (power of 2, >= LATENCY)
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   req_valid   fetch request valid
//   req_ready   responder can accept a request this cycle
//   req_addr    byte address of the instruction (PC value)
//   resp_valid  response word valid
//   resp_ready  consumer accepts the response this cycle
//   resp_inst   instruction word at the response FIFO head
//   resp_err    request was misaligned or out of range
//   ld_we       load-port write enable (honoured even while rst=1)
//   ld_addr     load-port word address
//   ld_data     load-port write data
// -----------------------------------------------------------------------------
module imem_fetch_resp #(
  parameter int AW      = 10,
  parameter int LATENCY = 2,
  parameter int OSTD    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_inst,
  output logic          resp_err,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  localparam logic [31:0]   NOP      = 32'h0000_0013;
  localparam int            CW       = $clog2(OSTD + 1);
  localparam int            PW       = (OSTD > 1) ? $clog2(OSTD) : 1;
  localparam logic [CW-1:0] OSTD_C   = CW'(OSTD);
  localparam logic [PW-1:0] PTR_LAST = PW'(OSTD - 1);

  // ---------------------------------------------------------------------------
  // Request side: outstanding counter and address decode
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          accept;
  logic          pop;
  logic          req_err;

  // Ready is taken from the registered count only. A response that completes
  // while the count is full does not open the request side in the same
  // cycle, which keeps req_ready free of any path from resp_ready.
  assign req_ready = !rst && (cnt_reg < OSTD_C);
  assign accept    = req_valid && req_ready;
  assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);

  always_comb begin
    cnt_next = cnt_reg;
    case ({accept, pop})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction memory. The read is registered and samples the old contents
  // when a load-port write hits the same word on the same edge (read-first).
  // The read register doubles as the data half of latency stage 0.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
    if (accept && !req_err) begin
      rd_data_reg <= mem[req_addr[AW+1:2]];
    end
  end

  // ---------------------------------------------------------------------------
  // Latency pipeline: LATENCY stages of {valid, err, data}, advancing every
  // cycle. The NOP substitution for errored requests happens at the FIFO
  // push, so the data path carries raw memory words only.
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] pipe_valid_reg;
  logic [LATENCY-1:0] pipe_err_reg;
  logic [31:0]        pipe_data [LATENCY];

  always_ff @(posedge clk) begin
    pipe_err_reg[0] <= req_err;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_err_reg[i] <= pipe_err_reg[i-1];
    end
    if (rst) begin
      pipe_valid_reg <= '0;
    end else begin
      pipe_valid_reg[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
      end
    end
  end

  assign pipe_data[0] = rd_data_reg;

  generate
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
      logic [31:0] data_reg;
      always_ff @(posedge clk) begin
        data_reg <= pipe_data[gi-1];
      end
      assign pipe_data[gi] = data_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Response FIFO. The outstanding limit guarantees that it never overflows,
  // so a push is never refused.
  // ---------------------------------------------------------------------------
  logic          push;
  logic [31:0]   push_inst;
  logic          push_err;
  logic [31:0]   fifo_inst [OSTD];
  logic [OSTD-1:0] fifo_err_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] fifo_cnt_reg;
  logic [31:0]   last_inst_reg;
  logic          last_err_reg;

  assign push      = pipe_valid_reg[LATENCY-1];
  assign push_err  = pipe_err_reg[LATENCY-1];
  assign push_inst = push_err ? NOP : pipe_data[LATENCY-1];

  assign resp_valid = (fifo_cnt_reg != '0);
  assign pop        = resp_valid && resp_ready;

  // With the FIFO empty, the outputs hold the most recently completed
  // response. That value is zero right after reset.
  assign resp_inst = resp_valid ? fifo_inst[rd_ptr_reg]    : last_inst_reg;
  assign resp_err  = resp_valid ? fifo_err_reg[rd_ptr_reg] : last_err_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr_reg]    <= push_inst;
      fifo_err_reg[wr_ptr_reg] <= push_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fifo_cnt_reg  <= '0;
      last_inst_reg <= '0;
      last_err_reg  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg    <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
        last_inst_reg <= fifo_inst[rd_ptr_reg];
        last_err_reg  <= fifo_err_reg[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_resp.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_resp
//
// Directed bench for imem_fetch_resp (AW=10, LATENCY=2, OSTD=4). Inputs are
// driven just after each rising edge. Outputs and handshakes are sampled on
// the falling edge. A reference queue built from a bench-side memory image
// predicts every response word, the cycle it first becomes valid, and
// req_ready. The directed sections add hand-computed values and edge numbers.
// -----------------------------------------------------------------------------
module tb_imem_fetch_resp;

  localparam int AW   = 10;
  localparam int LAT  = 2;
  localparam int OSTD = 4;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          req_valid  = 1'b0;
  logic [31:0]   req_addr   = '0;
  logic          resp_ready = 1'b0;
  logic          ld_we      = 1'b0;
  logic [AW-1:0] ld_addr    = '0;
  logic [31:0]   ld_data    = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_inst;
  logic          resp_err;

  always #5 clk = ~clk;

  imem_fetch_resp #(.AW(AW), .LATENCY(LAT), .OSTD(OSTD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_inst (resp_inst),
    .resp_err  (resp_err),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [1<<AW];
  logic [31:0] pop_inst[$];
  logic        pop_err[$];
  int          pop_edge[$];
  int          cyc      = 0;
  int          cnt_m    = 0;
  int          max_cnt  = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          last_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: sample on the falling edge, update the reference model
  // for the coming rising edge, then return just after that edge.
  task automatic tick();
    bit          acc;
    bit          pop;
    logic        e;
    logic [31:0] w;
    @(negedge clk);
    acc = req_valid && req_ready;
    pop = resp_valid && resp_ready;
    check("req_ready", 32'(req_ready), 32'(!rst && (cnt_m < OSTD)));
    check("resp_valid", 32'(resp_valid), 32'(exp_q.size() > 0 && exp_q[0].due <= cyc));
    if (resp_valid && exp_q.size() > 0) begin
      check("resp_inst", resp_inst, exp_q[0].inst);
      check("resp_err", 32'(resp_err), 32'(exp_q[0].err));
    end
    if (pop) begin
      pop_inst.push_back(resp_inst);
      pop_err.push_back(resp_err);
      pop_edge.push_back(cyc + 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (acc) begin
      e = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
      w = e ? 32'h0000_0013 : mem_m[req_addr[AW+1:2]];
      exp_q.push_back('{inst: w, err: e, due: cyc + 1 + LAT});
    end
    if (ld_we) mem_m[ld_addr] = ld_data;
    cnt_m = cnt_m + int'(acc) - int'(pop);
    if (cnt_m > max_cnt) max_cnt = cnt_m;
    if (rst) begin
      exp_q.delete();
      cnt_m = 0;
    end
    last_acc = acc;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    tick();
    ld_we   = 1'b0;
  endtask

  task automatic drain(input int n, input int budget);
    int k = 0;
    while (pop_inst.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("drain_count", 32'(pop_inst.size()), 32'(n));
  endtask

  task automatic clear_log();
    pop_inst.delete();
    pop_err.delete();
    pop_edge.delete();
  endtask

  logic [31:0] prog [4];
  int          e1;
  int          k;
  int          n;

  initial begin
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_0013;

    // Reset state
    @(posedge clk);
    #1;
    cyc = 1;
    rst = 1'b0;
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_inst", resp_inst, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h1);

    // Preload program and the last word of memory
    for (int i = 0; i < 4; i++) load_word(i, prog[i]);
    load_word(1023, 32'hCAFE_0001);

    // Back-to-back fetches, no bubbles
    clear_log();
    resp_ready = 1'b1;
    e1 = cyc + 1;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(i * 4);
      tick();
    end
    req_valid = 1'b0;
    drain(4, 20);
    for (int i = 0; i < 4 && i < pop_inst.size(); i++) begin
      check("t1_inst", pop_inst[i], prog[i]);
      check("t1_err", 32'(pop_err[i]), 32'h0);
      check("t1_edge", 32'(pop_edge[i]), 32'(e1 + LAT + 1 + i));
    end

    // Misaligned, out-of-range, and last in-range word
    clear_log();
    req_valid = 1'b1;
    req_addr = 32'h0000_0006; tick();
    req_addr = 32'h0000_1000; tick();
    req_addr = 32'h0000_0FFC; tick();
    req_valid = 1'b0;
    drain(3, 20);
    if (pop_inst.size() == 3) begin
      check("t2_misal_inst", pop_inst[0], 32'h0000_0013);
      check("t2_misal_err", 32'(pop_err[0]), 32'h1);
      check("t2_range_inst", pop_inst[1], 32'h0000_0013);
      check("t2_range_err", 32'(pop_err[1]), 32'h1);
      check("t2_last_inst", pop_inst[2], 32'hCAFE_0001);
      check("t2_last_err", 32'(pop_err[2]), 32'h0);
    end

    // Backpressure: exactly OSTD accepted, head held
    clear_log();
    resp_ready = 1'b0;
    req_valid = 1'b1;
    k = 0;
    repeat (8) begin
      req_addr = 32'(k * 4);
      tick();
      if (last_acc) k++;
    end
    req_valid = 1'b0;
    check("t3_accepted", 32'(k), 32'd4);
    check("t3_req_ready_full", 32'(req_ready), 32'h0);
    check("t3_head_held", resp_inst, 32'h0050_0093);
    resp_ready = 1'b1;
    drain(4, 20);
    for (int i = 0; i < 4 && i < pop_inst.size(); i++) begin
      check("t3_order", pop_inst[i], prog[i]);
    end
    check("t3_req_ready_free", 32'(req_ready), 32'h1);

    // Same-edge load returns old data, next fetch returns new
    load_word(5, 32'h1111_1111);
    clear_log();
    req_valid = 1'b1;
    req_addr  = 32'h0000_0014;
    ld_we     = 1'b1;
    ld_addr   = AW'(5);
    ld_data   = 32'h2222_2222;
    tick();
    ld_we = 1'b0;
    tick();
    req_valid = 1'b0;
    drain(2, 20);
    if (pop_inst.size() == 2) begin
      check("t4_old", pop_inst[0], 32'h1111_1111);
      check("t4_new", pop_inst[1], 32'h2222_2222);
    end

    // Reset with 3 requests in flight
    resp_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'(i * 4);
      tick();
    end
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t5_resp_valid", 32'(resp_valid), 32'h0);
    check("t5_req_ready", 32'(req_ready), 32'h1);
    check("t5_resp_inst", resp_inst, 32'h0);
    check("t5_resp_err", 32'(resp_err), 32'h0);
    clear_log();
    resp_ready = 1'b1;
    repeat (10) tick();
    check("t5_no_stale", 32'(pop_inst.size()), 32'h0);
    req_valid = 1'b1;
    req_addr = 32'h0000_0004;
    tick();
    req_valid = 1'b0;
    drain(1, 20);
    if (pop_inst.size() == 1) check("t5_retained", pop_inst[0], 32'h00A0_0113);

    // Random toggling over 1000 requests
    for (int i = 0; i < 16; i++) load_word(i, $urandom);
    clear_log();
    max_cnt = 0;
    k = 0;
    n = 0;
    while (k < 1000 && n < 20000) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_addr   = 32'($urandom_range(0, 15) * 4) | (($urandom_range(0, 9) == 0) ? 32'h1 : 32'h0);
      ld_we      = ($urandom_range(0, 7) == 0);
      ld_addr    = AW'($urandom_range(0, 15));
      ld_data    = $urandom;
      resp_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_acc) k++;
      n++;
    end
    req_valid  = 1'b0;
    ld_we      = 1'b0;
    resp_ready = 1'b1;
    check("t6_accepted", 32'(k), 32'd1000);
    drain(k, 40);
    check("t6_max_outstanding_ok", 32'(max_cnt <= OSTD), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
